pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage pipelined OTTER core (IF, DE, EX, MEM, WB).
- Owns the per-stage valid bits.
- Generates per-stage stall enables, branch flushes and EX-stage operand forwarding selects.
- Keeps hazard performance counters and a data-memory wait watchdog.
- The datapath pipeline registers consume its STALL_* and *_VALID outputs; the ALU operand muxes consume FWD_*.

Parameters:
CNT_W, 32, width of the STALL_COUNT and FLUSH_COUNT performance counters.
MAX_WAIT, 255, maximum consecutive qualified DMEM_BUSY cycles before MEM_TIMEOUT is raised.

Ports:
CLK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous active-low reset.
DE_RS1_ADDR  in  5  rs1 address of the instruction in DE.
DE_RS2_ADDR  in  5  rs2 address of the instruction in DE.
DE_RS1_USED  in  1  DE instruction reads rs1.
DE_RS2_USED  in  1  DE instruction reads rs2.
EX_RS1_ADDR  in  5  rs1 address of the instruction in EX.
EX_RS2_ADDR  in  5  rs2 address of the instruction in EX.
EX_RD  in  5  destination register of the instruction in EX.
EX_MEM_READ  in  1  EX instruction is a load.
BRANCH_TAKEN  in  1  EX redirects the PC (taken branch, JAL or JALR).
MEM_RD  in  5  destination register of the instruction in MEM.
MEM_REG_WRITE  in  1  MEM instruction writes the register file.
WB_RD  in  5  destination register of the instruction in WB.
WB_REG_WRITE  in  1  WB instruction writes the register file.
DMEM_BUSY  in  1  data memory has not completed the MEM-stage access.
STALL_PC  out  1  hold the PC.
STALL_IF  out  1  hold the IF/DE register.
STALL_DE  out  1  hold the DE/EX register.
STALL_EX  out  1  hold the EX/MEM register.
STALL_MEM  out  1  hold the MEM/WB register.
IF_DE_VALID  out  1  the IF/DE register holds a real instruction.
DE_EX_VALID  out  1  the DE/EX register holds a real instruction.
EX_MEM_VALID  out  1  the EX/MEM register holds a real instruction.
MEM_WB_VALID  out  1  the MEM/WB register holds a real instruction.
FWD_A_SEL  out  2  ALU operand A source: 00 register file, 01 EX/MEM ALU result, 10 WB write data.
FWD_B_SEL  out  2  ALU operand B source, same encoding as FWD_A_SEL.
STALL_COUNT  out  CNT_W  count of stalled cycles.
FLUSH_COUNT  out  CNT_W  count of branch flush events.
MEM_TIMEOUT  out  1  sticky data-memory timeout error.

Behaviour:
- Reset is asynchronous on RESET_N low. At reset, every valid bit, both counters, the wait counter and MEM_TIMEOUT are 0.
- STALL_* and FWD_* are combinational. With all valid bits 0 after reset they evaluate to 0.
- mem_wait = EX_MEM_VALID & DMEM_BUSY.
- load_use = DE_EX_VALID & IF_DE_VALID & EX_MEM_READ & (EX_RD != 0) & ((DE_RS1_USED & DE_RS1_ADDR == EX_RD) | (DE_RS2_USED & DE_RS2_ADDR == EX_RD)).
- flush = DE_EX_VALID & BRANCH_TAKEN.
- Priority is mem_wait, then flush, then load_use. The flush/load_use overlap is unreachable, since a load never branches; if both occur, flush wins.
- mem_wait: all STALL_* = 1. Valid bits IF_DE through EX_MEM hold. MEM_WB_VALID <= 0, inserting a WB bubble.
- flush: no stalls. IF_DE_VALID <= 0, DE_EX_VALID <= 0, EX_MEM_VALID <= 1, MEM_WB_VALID <= EX_MEM_VALID. FLUSH_COUNT increments.
- load_use: STALL_PC, STALL_IF and STALL_DE = 1; STALL_EX and STALL_MEM = 0. IF_DE_VALID holds, DE_EX_VALID <= 0, EX_MEM_VALID <= DE_EX_VALID, MEM_WB_VALID <= EX_MEM_VALID.
- Normal: no stalls. IF_DE_VALID <= 1, DE_EX_VALID <= IF_DE_VALID, EX_MEM_VALID <= DE_EX_VALID, MEM_WB_VALID <= EX_MEM_VALID.
- First instruction after reset release: IF_DE_VALID rises on the 1st edge and MEM_WB_VALID on the 4th.
- STALL_COUNT increments in every cycle where mem_wait | load_use. Both counters saturate at all-ones.
- Forwarding, A side:
  - FWD_A_SEL = 01 if EX_MEM_VALID & MEM_REG_WRITE & MEM_RD != 0 & MEM_RD == EX_RS1_ADDR.
  - Otherwise 10 if MEM_WB_VALID & WB_REG_WRITE & WB_RD != 0 & WB_RD == EX_RS1_ADDR.
  - Otherwise 00. MEM has priority over WB.
- Forwarding, B side: FWD_B_SEL uses the same rules with EX_RS2_ADDR.
- Watchdog: a wait counter increments during mem_wait and clears otherwise. When it reaches MAX_WAIT with mem_wait still asserted, MEM_TIMEOUT <= 1. MEM_TIMEOUT stays set until reset; the stall behaviour is unchanged.
- Reset asserted mid-stall or mid-flush clears all state immediately, with no completion of the in-flight event.

Test Plan:
- Reset release, no hazards: IF_DE_VALID..MEM_WB_VALID go 1 on edges 1..4; STALL_* = 0; counters 0.
- Load-use: EX load with EX_RD=5, DE_RS1_ADDR=5, DE_RS1_USED=1 for 1 cycle -> STALL_PC/IF/DE = 1 for 1 cycle, DE_EX_VALID=0 next cycle, STALL_COUNT=1. Repeat with EX_RD=0 -> no stall.
- Branch flush: BRANCH_TAKEN=1 with DE_EX_VALID=1 -> IF_DE_VALID=0 and DE_EX_VALID=0 next cycle, FLUSH_COUNT=1, no stall. Repeat with DE_EX_VALID=0 -> ignored.
- Forwarding: MEM_RD=WB_RD=EX_RS1_ADDR=7 both writing -> FWD_A_SEL=01. Deassert MEM_REG_WRITE -> 10. Register 0 in all stages -> 00.
- Memory wait: DMEM_BUSY=1 for 3 cycles during a load-use -> all STALL_*=1, load_use ignored, MEM_WB_VALID=0, STALL_COUNT=3. MAX_WAIT=4 with busy held 6 cycles -> MEM_TIMEOUT=1 and sticky.
- Async reset mid mem_wait: RESET_N low between edges -> valid bits, counters and MEM_TIMEOUT = 0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: the datapath drives stage/register info, the
// controller returns stalls, valid bits, forwarding selects and counters.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       DE_RS1_ADDR;
  logic [4:0]       DE_RS2_ADDR;
  logic             DE_RS1_USED;
  logic             DE_RS2_USED;
  logic [4:0]       EX_RS1_ADDR;
  logic [4:0]       EX_RS2_ADDR;
  logic [4:0]       EX_RD;
  logic             EX_MEM_READ;
  logic             BRANCH_TAKEN;
  logic [4:0]       MEM_RD;
  logic             MEM_REG_WRITE;
  logic [4:0]       WB_RD;
  logic             WB_REG_WRITE;
  logic             DMEM_BUSY;
  logic             STALL_PC;
  logic             STALL_IF;
  logic             STALL_DE;
  logic             STALL_EX;
  logic             STALL_MEM;
  logic             IF_DE_VALID;
  logic             DE_EX_VALID;
  logic             EX_MEM_VALID;
  logic             MEM_WB_VALID;
  logic [1:0]       FWD_A_SEL;
  logic [1:0]       FWD_B_SEL;
  logic [CNT_W-1:0] STALL_COUNT;
  logic [CNT_W-1:0] FLUSH_COUNT;
  logic             MEM_TIMEOUT;

  modport master (
    output DE_RS1_ADDR, DE_RS2_ADDR, DE_RS1_USED, DE_RS2_USED,
           EX_RS1_ADDR, EX_RS2_ADDR, EX_RD, EX_MEM_READ, BRANCH_TAKEN,
           MEM_RD, MEM_REG_WRITE, WB_RD, WB_REG_WRITE, DMEM_BUSY,
    input  STALL_PC, STALL_IF, STALL_DE, STALL_EX, STALL_MEM,
           IF_DE_VALID, DE_EX_VALID, EX_MEM_VALID, MEM_WB_VALID,
           FWD_A_SEL, FWD_B_SEL, STALL_COUNT, FLUSH_COUNT, MEM_TIMEOUT
  );

  modport slave (
    input  DE_RS1_ADDR, DE_RS2_ADDR, DE_RS1_USED, DE_RS2_USED,
           EX_RS1_ADDR, EX_RS2_ADDR, EX_RD, EX_MEM_READ, BRANCH_TAKEN,
           MEM_RD, MEM_REG_WRITE, WB_RD, WB_REG_WRITE, DMEM_BUSY,
    output STALL_PC, STALL_IF, STALL_DE, STALL_EX, STALL_MEM,
           IF_DE_VALID, DE_EX_VALID, EX_MEM_VALID, MEM_WB_VALID,
           FWD_A_SEL, FWD_B_SEL, STALL_COUNT, FLUSH_COUNT, MEM_TIMEOUT
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage OTTER pipeline: stage valid bits,
// stalls, branch flushes, EX forwarding, hazard counters, DMEM watchdog.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input logic                  CLK,
  input logic                  RESET_N,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic              if_de_q, de_ex_q, ex_mem_q, mem_wb_q;
  logic              if_de_d, de_ex_d, ex_mem_d, mem_wb_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_q;

  logic mem_wait, load_use, flush;
  logic stall_pc, stall_if, stall_de, stall_ex, stall_mem;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mem_v, input logic mem_we, input logic [4:0] mem_rd,
    input logic       wb_v,  input logic wb_we,  input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_v && mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
      sel = 2'b01;
    else if (wb_v && wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    mem_wait = ex_mem_q & hz.DMEM_BUSY;
    flush    = de_ex_q & hz.BRANCH_TAKEN;
    load_use = de_ex_q & if_de_q & hz.EX_MEM_READ & (hz.EX_RD != 5'd0) &
               ((hz.DE_RS1_USED & (hz.DE_RS1_ADDR == hz.EX_RD)) |
                (hz.DE_RS2_USED & (hz.DE_RS2_ADDR == hz.EX_RD)));

    stall_pc  = 1'b0;
    stall_if  = 1'b0;
    stall_de  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    if_de_d   = 1'b1;
    de_ex_d   = if_de_q;
    ex_mem_d  = de_ex_q;
    mem_wb_d  = ex_mem_q;

    // mem_wait outranks flush, which outranks load_use
    if (mem_wait) begin
      stall_pc  = 1'b1;
      stall_if  = 1'b1;
      stall_de  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      if_de_d   = if_de_q;
      de_ex_d   = de_ex_q;
      ex_mem_d  = ex_mem_q;
      mem_wb_d  = 1'b0;
    end else if (flush) begin
      if_de_d  = 1'b0;
      de_ex_d  = 1'b0;
      ex_mem_d = 1'b1;
    end else if (load_use) begin
      stall_pc = 1'b1;
      stall_if = 1'b1;
      stall_de = 1'b1;
      if_de_d  = if_de_q;
      de_ex_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      if_de_q     <= 1'b0;
      de_ex_q     <= 1'b0;
      ex_mem_q    <= 1'b0;
      mem_wb_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if_de_q  <= if_de_d;
      de_ex_q  <= de_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      if ((mem_wait || load_use) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (!mem_wait && flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
      // wait_q counts prior busy cycles, so the (MAX_WAIT+1)th one trips it
      if (mem_wait) begin
        if (wait_q != WAIT_W'(MAX_WAIT))
          wait_q <= wait_q + 1'b1;
        else
          timeout_q <= 1'b1;
      end else begin
        wait_q <= '0;
      end
    end
  end

  assign hz.STALL_PC     = stall_pc;
  assign hz.STALL_IF     = stall_if;
  assign hz.STALL_DE     = stall_de;
  assign hz.STALL_EX     = stall_ex;
  assign hz.STALL_MEM    = stall_mem;
  assign hz.IF_DE_VALID  = if_de_q;
  assign hz.DE_EX_VALID  = de_ex_q;
  assign hz.EX_MEM_VALID = ex_mem_q;
  assign hz.MEM_WB_VALID = mem_wb_q;
  assign hz.STALL_COUNT  = stall_cnt_q;
  assign hz.FLUSH_COUNT  = flush_cnt_q;
  assign hz.MEM_TIMEOUT  = timeout_q;
  assign hz.FWD_A_SEL    = fwd_sel(hz.EX_RS1_ADDR, ex_mem_q, hz.MEM_REG_WRITE, hz.MEM_RD,
                                   mem_wb_q, hz.WB_REG_WRITE, hz.WB_RD);
  assign hz.FWD_B_SEL    = fwd_sel(hz.EX_RS2_ADDR, ex_mem_q, hz.MEM_REG_WRITE, hz.MEM_RD,
                                   mem_wb_q, hz.WB_REG_WRITE, hz.WB_RD);
endmodule
